// File: rtl/axis_packet_deframer.sv
// axis_packet_deframer: extracts SOF/LEN/payload/CHK frames from a byte stream,
// buffers the payload until the checksum verifies, then replays it as an AXI-Stream packet.
module axis_packet_deframer #(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    output logic        m_axis_tlast_o,
    input  logic        m_axis_tready_i,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] frame_cnt_o
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, SEND} state_t;
    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d, chk_q, chk_d;
    logic [AW-1:0]   idx_q, idx_d, rd_q, rd_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      buf_q [MAX_LEN];
    logic [7:0]      buf_d [MAX_LEN];
    logic            s_ready_q, s_ready_d, m_valid_q, m_valid_d;
    logic            ok_q, ok_d, err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            s_acc, m_acc, last;

    assign s_acc = s_axis_tvalid_i && s_ready_q;
    assign m_acc = m_valid_q && m_axis_tready_i;
    assign last  = m_valid_q && (8'(rd_q) == len_q - 8'd1);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        tmo_d     = '0;
        buf_d     = buf_q;
        m_valid_d = m_valid_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        cnt_d     = cnt_q;
        case (state_q)
            HUNT: state_d = (s_acc && s_axis_tdata_i == 8'h7E) ? LEN : HUNT;
            LEN: if (s_acc) begin
                if (s_axis_tdata_i == 8'h00 || s_axis_tdata_i > MAX_B) begin
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = HUNT;
                end else begin
                    len_d   = s_axis_tdata_i;
                    chk_d   = s_axis_tdata_i;
                    idx_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (s_acc) begin
                buf_d[idx_q] = s_axis_tdata_i;
                chk_d        = chk_q + s_axis_tdata_i;
                idx_d        = idx_q + 1'b1;
                state_d      = (8'(idx_q) == len_q - 8'd1) ? CHECK : PAYLOAD;
            end
            CHECK: if (s_acc) begin
                if (8'(chk_q + s_axis_tdata_i) == 8'h00) begin
                    ok_d      = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                    rd_d      = '0;
                    m_valid_d = 1'b1;
                    state_d   = SEND;
                end else begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = HUNT;
                end
            end
            SEND: if (m_acc) begin
                m_valid_d = !last;
                rd_d      = last ? rd_q : rd_q + 1'b1;
                state_d   = last ? HUNT : SEND;
            end
            default: state_d = HUNT;
        endcase
        // Idle cycles only count while a frame is partially received.
        if ((state_q == LEN || state_q == PAYLOAD || state_q == CHECK) && !s_acc) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                err_d   = 1'b1;
                code_d  = 2'd3;
                state_d = HUNT;
            end
        end
        s_ready_d = (state_d != SEND);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= HUNT;
            len_q     <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            tmo_q     <= '0;
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            tmo_q     <= tmo_d;
            buf_q     <= buf_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_axis_tready_o = s_ready_q;
    assign m_axis_tvalid_o = m_valid_q;
    assign m_axis_tdata_o  = m_valid_q ? buf_q[rd_q] : 8'h00;
    assign m_axis_tlast_o  = last;
    assign frame_ok_o      = ok_q;
    assign frame_err_o     = err_q;
    assign err_code_o      = code_q;
    assign frame_cnt_o     = cnt_q;
endmodule

// File: tb/tb_axis_packet_deframer.sv
// tb_axis_packet_deframer: scenario tasks plus randomized frames checked against a byte-level frame model.
module tb_axis_packet_deframer;
    localparam int ML = 16;
    localparam int T  = 200;
    typedef logic [7:0] bq_t[$];

    logic        clk = 0, rst = 1;
    logic [7:0]  s_data = 0;
    logic        s_valid = 0, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready = 1;
    logic        ok, err;
    logic [1:0]  code;
    logic [15:0] cnt;

    int checks = 0, failures = 0;
    int bp_mode = 0;
    int cyc = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic [1:0] errs[$];
    int ok_n = 0, viol = 0;
    logic pv = 0, pr = 0, pl = 0, perr = 0;
    logic [7:0] pd = 0;

    axis_packet_deframer #(.MAX_LEN(ML), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
        .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid), .m_axis_tlast_o(m_last),
        .m_axis_tready_i(m_ready),
        .frame_ok_o(ok), .frame_err_o(err), .err_code_o(code), .frame_cnt_o(cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0: m_ready = 1;
            1: m_ready = ~m_ready;
            2: m_ready = ($urandom_range(0, 9) < 7);
            default: m_ready = 0;
        endcase
    end

    // Observer: collects transfers and pulses, and counts handshake-rule violations.
    always @(negedge clk) begin
        if (rst) begin
            pv <= 0;
            perr <= 0;
        end else begin
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) viol <= viol + 1;
            if (pv && pr && !pl && !m_valid) viol <= viol + 1;
            if (m_valid && s_ready) viol <= viol + 1;
            if (err && perr) viol <= viol + 1;
            if (m_valid && m_ready) got.push_back({m_last, m_data});
            if (ok) ok_n <= ok_n + 1;
            if (err) errs.push_back(code);
            pv <= m_valid; pr <= m_ready; pl <= m_last; pd <= m_data; perr <= err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_data = b;
        s_valid = 1;
        @(negedge clk);
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout byte=%02h s_ready stuck at %0b, required 1", b, s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 0;
        s_data = 0;
    endtask

    task automatic send_bytes(input bq_t q, input int gap_max);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (got.size() < n && k < 3000) begin
            idle(1);
            k++;
        end
        idle(4);
    endtask

    function automatic bq_t make_frame(input int len, input bit good);
        bq_t q;
        logic [7:0] s = 8'(len);
        q.push_back(8'h7E);
        q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            q.push_back(8'($urandom));
            s = s + q[q.size() - 1];
        end
        q.push_back(good ? 8'(-s) : 8'(-s) + 8'($urandom_range(1, 255)));
        return q;
    endfunction

    // Reference rule: a frame is good when its LEN is legal and LEN+payload+CHK wraps to zero.
    function automatic bit frame_good(input bq_t f);
        int sum = 0;
        if (f[1] == 0 || f[1] > ML) return 0;
        for (int i = 1; i < f.size(); i++) sum += f[i];
        return (sum % 256) == 0;
    endfunction

    task automatic expect_payload(input bq_t f);
        for (int i = 0; i < f[1]; i++) exp_q.push_back({(i == f[1] - 1) ? 1'b1 : 1'b0, f[i + 2]});
    endtask

    task automatic test_reset;
        rst = 1;
        idle(3);
        checks++;
        if (s_ready !== 1 || m_valid !== 0 || m_last !== 0 || m_data !== 0) begin
            failures++;
            $display("FAIL reset_stream got ready=%0b valid=%0b last=%0b data=%02h required 1 0 0 00", s_ready, m_valid, m_last, m_data);
        end
        checks++;
        if (ok !== 0 || err !== 0 || code !== 0 || cnt !== 0) begin
            failures++;
            $display("FAIL reset_status got ok=%0b err=%0b code=%0d cnt=%0d required 0 0 0 0", ok, err, code, cnt);
        end
        rst = 0;
        idle(2);
        checks++;
        if (s_ready !== 1 || m_valid !== 0 || cnt !== 0) begin
            failures++;
            $display("FAIL reset_release got ready=%0b valid=%0b cnt=%0d required 1 0 0", s_ready, m_valid, cnt);
        end
    endtask

    task automatic test_good;
        bq_t f = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        got.delete();
        send_bytes(f[0:4], 0);
        send_byte(f[5]);
        checks++;
        if (m_valid !== 1 || ok !== 1 || m_data !== 8'h11 || s_ready !== 0) begin
            failures++;
            $display("FAIL good_first got valid=%0b ok=%0b data=%02h ready=%0b required 1 1 11 0", m_valid, ok, m_data, s_ready);
        end
        wait_out(3);
        checks++;
        if (got.size() != 3 || got[0] !== 9'h011 || got[1] !== 9'h022 || got[2] !== 9'h133) begin
            failures++;
            $display("FAIL good_payload got n=%0d %p required 011 022 133", got.size(), got);
        end
        checks++;
        if (cnt !== 1 || m_valid !== 0) begin
            failures++;
            $display("FAIL good_cnt got cnt=%0d valid=%0b required 1 0", cnt, m_valid);
        end
    endtask

    task automatic test_bad_chk;
        bq_t f = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        got.delete();
        errs.delete();
        send_bytes(f, 0);
        idle(3);
        checks++;
        if (errs.size() != 1 || code !== 2) begin
            failures++;
            $display("FAIL bad_chk got errs=%0d code=%0d required 1 2", errs.size(), code);
        end
        checks++;
        if (got.size() != 0 || cnt !== 1) begin
            failures++;
            $display("FAIL bad_chk_out got bytes=%0d cnt=%0d required 0 1", got.size(), cnt);
        end
    endtask

    task automatic test_bad_len;
        got.delete();
        errs.delete();
        send_bytes('{8'h7E, 8'h00}, 0);
        idle(2);
        checks++;
        if (errs.size() != 1 || code !== 1) begin
            failures++;
            $display("FAIL bad_len_zero got errs=%0d code=%0d required 1 1", errs.size(), code);
        end
        send_bytes('{8'h7E, 8'(ML + 1)}, 0);
        idle(2);
        checks++;
        if (errs.size() != 2 || code !== 1) begin
            failures++;
            $display("FAIL bad_len_big got errs=%0d code=%0d required 2 1", errs.size(), code);
        end
        send_bytes('{8'h7E, 8'h01, 8'h7E, 8'h81}, 0);
        wait_out(1);
        checks++;
        if (got.size() != 1 || got[0] !== 9'h17E || cnt !== 2) begin
            failures++;
            $display("FAIL bad_len_recover got n=%0d first=%03h cnt=%0d required 1 17e 2", got.size(), got.size() ? got[0] : 9'h0, cnt);
        end
    endtask

    task automatic test_backpressure;
        int v0 = viol;
        got.delete();
        bp_mode = 1;
        send_bytes('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
        wait_out(3);
        bp_mode = 0;
        checks++;
        if (got.size() != 3 || got[0] !== 9'h011 || got[1] !== 9'h022 || got[2] !== 9'h133) begin
            failures++;
            $display("FAIL bp_payload got n=%0d %p required 011 022 133", got.size(), got);
        end
        checks++;
        if (viol != v0 || cnt !== 3) begin
            failures++;
            $display("FAIL bp_rules got violations=%0d cnt=%0d required 0 3", viol - v0, cnt);
        end
    endtask

    task automatic test_timeout;
        bq_t f;
        int k = 0;
        got.delete();
        errs.delete();
        send_bytes('{8'h7E, 8'h02, 8'hAA}, 0);
        idle(T - 3);
        checks++;
        if (errs.size() != 0 || s_ready !== 1) begin
            failures++;
            $display("FAIL timeout_early got errs=%0d ready=%0b required 0 1", errs.size(), s_ready);
        end
        while (errs.size() == 0 && k < 10) begin
            idle(1);
            k++;
        end
        checks++;
        if (errs.size() != 1 || code !== 3) begin
            failures++;
            $display("FAIL timeout_code got errs=%0d code=%0d required 1 3", errs.size(), code);
        end
        f = make_frame(5, 1);
        exp_q.delete();
        expect_payload(f);
        send_bytes(f, 1);
        wait_out(exp_q.size());
        checks++;
        if (got != exp_q || cnt !== 4) begin
            failures++;
            $display("FAIL timeout_next got %p cnt=%0d required %p cnt=4", got, cnt, exp_q);
        end
    endtask

    task automatic test_back_to_back;
        bq_t f1 = make_frame(4, 1);
        bq_t f2 = make_frame(ML, 1);
        int k = 0, t0;
        got.delete();
        exp_q.delete();
        expect_payload(f1);
        expect_payload(f2);
        send_bytes(f1, 0);
        @(negedge clk);
        while (!(m_valid && m_ready && m_last) && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1 || m_valid !== 0) begin
            failures++;
            $display("FAIL b2b_return got ready=%0b valid=%0b required 1 0", s_ready, m_valid);
        end
        t0 = cyc;
        send_byte(f2[0]);
        checks++;
        if (cyc - t0 != 1) begin
            failures++;
            $display("FAIL b2b_sof_latency got %0d cycles required 1", cyc - t0);
        end
        send_bytes(f2[1:$], 0);
        wait_out(exp_q.size());
        checks++;
        if (got != exp_q || cnt !== 6) begin
            failures++;
            $display("FAIL b2b_payload got n=%0d cnt=%0d required n=%0d cnt=6", got.size(), cnt, exp_q.size());
        end
    endtask

    task automatic test_random;
        bq_t f;
        logic [1:0] exp_err[$];
        int exp_ok = 0, ok0 = ok_n, v0 = viol, kind;
        logic [15:0] cnt0 = cnt;
        got.delete();
        errs.delete();
        exp_q.delete();
        bp_mode = 2;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'h7D)));
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                f = '{8'h7E, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255))};
                exp_err.push_back(2'd1);
            end else begin
                f = make_frame($urandom_range(1, ML), kind > 2);
                if (frame_good(f)) begin
                    expect_payload(f);
                    exp_ok++;
                end else exp_err.push_back(2'd2);
            end
            send_bytes(f, 2);
        end
        wait_out(exp_q.size());
        bp_mode = 0;
        checks++;
        if (got != exp_q) begin
            failures++;
            $display("FAIL rand_payload got n=%0d required n=%0d", got.size(), exp_q.size());
        end
        checks++;
        if (errs != exp_err) begin
            failures++;
            $display("FAIL rand_errors got %p required %p", errs, exp_err);
        end
        checks++;
        if (ok_n - ok0 != exp_ok || cnt !== 16'(cnt0 + exp_ok)) begin
            failures++;
            $display("FAIL rand_count got ok=%0d cnt=%0d required ok=%0d cnt=%0d", ok_n - ok0, cnt, exp_ok, 16'(cnt0 + exp_ok));
        end
        checks++;
        if (viol != v0) begin
            failures++;
            $display("FAIL rand_handshake got violations=%0d required 0", viol - v0);
        end
    endtask

    task automatic test_reset_mid;
        bq_t f;
        got.delete();
        bp_mode = 3;
        send_bytes('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
        idle(2);
        checks++;
        if (m_valid !== 1 || s_ready !== 0) begin
            failures++;
            $display("FAIL rst_mid_send got valid=%0b ready=%0b required 1 0", m_valid, s_ready);
        end
        rst = 1;
        #1;
        checks++;
        if (m_valid !== 0 || m_last !== 0 || m_data !== 0 || cnt !== 0 || s_ready !== 1) begin
            failures++;
            $display("FAIL rst_mid_outputs got valid=%0b last=%0b data=%02h cnt=%0d ready=%0b required 0 0 00 0 1", m_valid, m_last, m_data, cnt, s_ready);
        end
        idle(2);
        rst = 0;
        bp_mode = 0;
        idle(1);
        got.delete();
        f = '{8'h7E, 8'h01, 8'h55, 8'hAA};
        exp_q.delete();
        expect_payload(f);
        send_bytes(f, 0);
        wait_out(1);
        checks++;
        if (got != exp_q || cnt !== 1) begin
            failures++;
            $display("FAIL rst_mid_next got %p cnt=%0d required %p cnt=1", got, cnt, exp_q);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_chk();
        test_bad_len();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
